motor_rodadas: RTL and testbench

MOTOR_RODADAS -- requirements
Module: motor_rodadas

---
 rtl/motor_rodadas.sv | 144 ++++++++++++++
 tb/tb_motor_rodadas.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_rodadas.sv
// Round engine for a reaction game: picks an LFSR-driven target button each round,
// waits for a single fresh press or a timeout, and scores hits, misses and rounds.
module motor_rodadas #(
    parameter int          NB      = 4,
    parameter int          RODADAS = 3,
    parameter int          TIMEOUT = 5000,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic [NB-1:0] botoes,
    output logic [NB-1:0] alvo,
    output logic [3:0]    acertos,
    output logic [3:0]    erros,
    output logic [3:0]    rodada,
    output logic          pronto,
    output logic          db_timeout,
    output logic [2:0]    db_estado,
    output logic [15:0]   db_lfsr
);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        SORTEIA = 3'd1,
        ESPERA  = 3'd2,
        COMPARA = 3'd3,
        PROXIMA = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [15:0] TEMPO_MAX = 16'(TIMEOUT - 1);
    localparam logic [3:0]  ULTIMA    = 4'(RODADAS);

    estado_t       estado, prox;
    logic [15:0]   timer;
    logic [15:0]   indice;
    logic [NB-1:0] jogada_reg;
    logic          anterior;
    logic          tem_jogada;
    logic          jogada;

    logic iniciar_jogo, ld_alvo, ld_jogada, conta, tempo_esgotado, compara, avanca;

    function automatic logic [3:0] inc_sat(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // A press is a rising edge of "any button"; the history register runs in
    // every state, so edges outside ESPERA are simply lost rather than queued.
    assign tem_jogada = |botoes;
    assign jogada     = tem_jogada & ~anterior;
    assign indice     = db_lfsr % 16'(NB);
    assign pronto     = (estado == FIM);
    assign db_estado  = estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox;
    end

    always_comb begin
        prox           = estado;
        iniciar_jogo   = 1'b0;
        ld_alvo        = 1'b0;
        ld_jogada      = 1'b0;
        conta          = 1'b0;
        tempo_esgotado = 1'b0;
        compara        = 1'b0;
        avanca         = 1'b0;
        case (estado)
            INICIAL, FIM: begin
                if (iniciar) begin
                    iniciar_jogo = 1'b1;
                    prox         = SORTEIA;
                end
            end
            SORTEIA: begin
                ld_alvo = 1'b1;
                prox    = ESPERA;
            end
            ESPERA: begin
                if (jogada) begin
                    ld_jogada = 1'b1;
                    prox      = COMPARA;
                end else if (timer == TEMPO_MAX) begin
                    tempo_esgotado = 1'b1;
                    prox           = PROXIMA;
                end else begin
                    conta = 1'b1;
                end
            end
            COMPARA: begin
                compara = 1'b1;
                prox    = PROXIMA;
            end
            PROXIMA: begin
                avanca = 1'b1;
                prox   = (rodada + 4'd1 == ULTIMA) ? FIM : SORTEIA;
            end
            default: prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_lfsr    <= SEED;
            alvo       <= '0;
            acertos    <= '0;
            erros      <= '0;
            rodada     <= '0;
            db_timeout <= 1'b0;
            timer      <= '0;
            anterior   <= 1'b0;
            jogada_reg <= '0;
        end else begin
            db_lfsr  <= {1'b0, db_lfsr[15:1]} ^ (db_lfsr[0] ? 16'hB400 : 16'h0000);
            anterior <= tem_jogada;
            if (iniciar_jogo) begin
                acertos    <= '0;
                erros      <= '0;
                rodada     <= '0;
                db_timeout <= 1'b0;
            end
            if (ld_alvo) begin
                alvo  <= NB'(1) << indice;
                timer <= '0;
            end
            if (conta)     timer      <= timer + 16'd1;
            if (ld_jogada) jogada_reg <= botoes;
            if (tempo_esgotado) begin
                erros      <= inc_sat(erros);
                db_timeout <= 1'b1;
            end
            if (compara) begin
                if (jogada_reg == alvo) acertos <= inc_sat(acertos);
                else                    erros   <= inc_sat(erros);
                db_timeout <= 1'b0;
            end
            if (avanca) rodada <= inc_sat(rodada);
        end
    end

endmodule

// File: tb/tb_motor_rodadas.sv
// Directed and randomized game sessions for motor_rodadas, scored against a
// round-level model of the game rules and an arithmetic LFSR reference.
module tb_motor_rodadas;

    localparam int          NB      = 4;
    localparam int          RODADAS = 3;
    localparam int          TIMEOUT = 8;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic [NB-1:0] alvo;
    logic [3:0]    acertos, erros, rodada;
    logic          pronto, db_timeout;
    logic [2:0]    db_estado;
    logic [15:0]   db_lfsr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] m_lfsr = SEED;
    logic [15:0] m_prev = SEED;
    int          exp_acertos, exp_erros, exp_rodada;
    logic        exp_to;

    motor_rodadas #(.NB(NB), .RODADAS(RODADAS), .TIMEOUT(TIMEOUT), .SEED(SEED)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .alvo(alvo), .acertos(acertos), .erros(erros), .rodada(rodada),
        .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado),
        .db_lfsr(db_lfsr)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    // Galois step expressed arithmetically: halve, and fold the mask back in on odd values.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int unsigned x;
        x = int'(v) / 2;
        if (int'(v) % 2 == 1) x = x ^ 32'hB400;
        return 16'(x);
    endfunction

    task automatic step();
        @(posedge clock);
        m_prev = m_lfsr;
        m_lfsr = reset ? SEED : lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 40 && db_estado !== s; i++) step();
        chk(tag, 32'(db_estado), 32'(s));
    endtask

    task automatic start_game(input bit hold);
        iniciar = 1'b1;
        step();
        if (!hold) iniciar = 1'b0;
        exp_acertos = 0; exp_erros = 0; exp_rodada = 0; exp_to = 1'b0;
        chk("start_state", 32'(db_estado), 32'd1);
        chk("start_acertos", 32'(acertos), 32'd0);
        chk("start_erros", 32'(erros), 32'd0);
        chk("start_rodada", 32'(rodada), 32'd0);
        chk("start_pronto", 32'(pronto), 32'd0);
        chk("start_timeout", 32'(db_timeout), 32'd0);
    endtask

    // kind: 0 correct, 1 wrong single/multi pattern, 2 no press (timeout),
    //       3 correct press on the last timer cycle, 4 all buttons at once.
    task automatic do_round(input int kind, input bit hold);
        logic [NB-1:0] tgt, pat;
        wait_state(3'd2, "enter_espera");
        tgt = NB'(1) << (m_prev % NB);
        chk("alvo", 32'(alvo), 32'(tgt));
        chk("lfsr", 32'(db_lfsr), 32'(m_lfsr));
        if (kind == 2) begin
            for (int i = 0; i < TIMEOUT - 1; i++) begin
                step();
                chk("espera_wait", 32'(db_estado), 32'd2);
            end
            step();
            exp_erros++;
            exp_to = 1'b1;
            chk("timeout_exit", 32'(db_estado), 32'd4);
            chk("timeout_flag", 32'(db_timeout), 32'd1);
            chk("timeout_erros", 32'(erros), 32'(exp_erros));
        end else begin
            if (kind == 3) begin
                for (int i = 0; i < TIMEOUT - 1; i++) begin
                    step();
                    chk("espera_late", 32'(db_estado), 32'd2);
                end
            end
            case (kind)
                1: begin
                    pat = NB'($urandom_range(1, (1 << NB) - 1));
                    while (pat == tgt) pat = NB'($urandom_range(1, (1 << NB) - 1));
                end
                4:       pat = '1;
                default: pat = tgt;
            endcase
            botoes = pat;
            step();
            chk("consume", 32'(db_estado), 32'd3);
            if (!hold) botoes = '0;
            step();
            if (pat == tgt) exp_acertos++;
            else            exp_erros++;
            exp_to = 1'b0;
            chk("compare_state", 32'(db_estado), 32'd4);
            chk("compare_acertos", 32'(acertos), 32'(exp_acertos));
            chk("compare_erros", 32'(erros), 32'(exp_erros));
            chk("compare_timeout", 32'(db_timeout), 32'd0);
        end
        step();
        exp_rodada++;
        chk("round_state", 32'(db_estado), (exp_rodada == RODADAS) ? 32'd5 : 32'd1);
        chk("round_rodada", 32'(rodada), 32'(exp_rodada));
        chk("round_pronto", 32'(pronto), 32'(exp_rodada == RODADAS));
        chk("round_timeout", 32'(db_timeout), 32'(exp_to));
        chk("invariant", 32'(acertos) + 32'(erros), 32'(rodada));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 32'(db_estado), 32'd0);
        chk({tag, "_alvo"}, 32'(alvo), 32'd0);
        chk({tag, "_counts"}, {20'd0, acertos, erros, rodada}, 32'd0);
        chk({tag, "_flags"}, {30'd0, pronto, db_timeout}, 32'd0);
        chk({tag, "_lfsr"}, 32'(db_lfsr), 32'(m_lfsr));
    endtask

    initial begin
        exp_acertos = 0; exp_erros = 0; exp_rodada = 0; exp_to = 1'b0;

        // Reset state, and release of reset does not start a game
        step(); step();
        check_idle("reset");
        chk("reset_seed", 32'(db_lfsr), 32'(SEED));
        reset = 1'b0;
        repeat (3) step();
        check_idle("post_reset");

        // Perfect game
        start_game(1'b0);
        for (int r = 0; r < RODADAS; r++) do_round(0, 1'b0);
        chk("win_acertos", 32'(acertos), 32'd3);
        chk("win_erros", 32'(erros), 32'd0);
        step();
        chk("fim_holds", 32'(db_estado), 32'd5);
        chk("fim_pronto", 32'(pronto), 32'd1);

        // Never press: every round times out
        start_game(1'b0);
        for (int r = 0; r < RODADAS; r++) do_round(2, 1'b0);
        chk("to_acertos", 32'(acertos), 32'd0);
        chk("to_erros", 32'(erros), 32'd3);

        // All buttons, then a button held through SORTEIA, then a last-cycle press
        start_game(1'b0);
        do_round(4, 1'b1);
        do_round(2, 1'b0);
        botoes = '0;
        step();
        do_round(3, 1'b0);
        chk("mix_acertos", 32'(acertos), 32'd1);
        chk("mix_erros", 32'(erros), 32'd2);

        // Reset asserted in ESPERA of round 2
        start_game(1'b0);
        do_round(0, 1'b0);
        wait_state(3'd2, "round2_espera");
        reset = 1'b1;
        m_lfsr = SEED;
        step();
        check_idle("midgame_reset");
        chk("midgame_seed", 32'(db_lfsr), 32'h0000ACE1);
        reset = 1'b0;
        repeat (2) step();
        check_idle("midgame_idle");
        start_game(1'b0);
        do_round(0, 1'b0);

        // iniciar held throughout: ignored mid-game, restarts straight out of FIM
        reset = 1'b1;
        m_lfsr = SEED;
        step();
        reset = 1'b0;
        step();
        start_game(1'b1);
        for (int r = 0; r < RODADAS; r++) do_round(0, 1'b0);
        step();
        exp_acertos = 0; exp_erros = 0; exp_rodada = 0; exp_to = 1'b0;
        chk("restart_state", 32'(db_estado), 32'd1);
        chk("restart_counts", {20'd0, acertos, erros, rodada}, 32'd0);
        chk("restart_pronto", 32'(pronto), 32'd0);
        iniciar = 1'b0;

        // Randomized round kinds against the model
        for (int r = 0; r < RODADAS; r++) do_round(int'($urandom_range(0, 4)), 1'b0);
        for (int g = 0; g < 4; g++) begin
            start_game(1'b0);
            for (int r = 0; r < RODADAS; r++) do_round(int'($urandom_range(0, 4)), 1'b0);
            chk("rand_acertos", 32'(acertos), 32'(exp_acertos));
            chk("rand_erros", 32'(erros), 32'(exp_erros));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
